// File: rtl/cam_bucket_ctrl.sv
// Session-table bucket controller: hashes keys to a direct-mapped RAM bucket and
// performs lookup/insert/delete with a valid/ready request and response channel.
module cam_bucket_ctrl #(
  parameter int A = 9,
  parameter int K = 48,
  parameter int V = 14,
  parameter int D = 64
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_ReqValid,
  output logic         o_ReqReady,
  input  logic [1:0]   i_ReqOp,
  input  logic [K-1:0] i_ReqKey,
  input  logic [V-1:0] i_ReqValue,
  output logic         o_RespValid,
  input  logic         i_RespReady,
  output logic [1:0]   o_RespOp,
  output logic         o_RespHit,
  output logic [V-1:0] o_RespValue,
  output logic         o_InitDone,
  output logic         o_RwEnb,
  output logic [A-1:0] o_RwAddr,
  output logic [D-1:0] o_RwData,
  input  logic [D-1:0] i_RwDataOut,
  output logic         o_WrEnb,
  output logic [A-1:0] o_WrAddr,
  output logic [D-1:0] o_WrData
);

  localparam int NCHUNK = (K + A - 1) / A;
  localparam int KPW    = NCHUNK * A;

  typedef enum logic [2:0] {INIT, IDLE, READ, EVAL, RESP} state_t;

  state_t         r_state;
  logic [1:0]     r_op;
  logic [K-1:0]   r_key;
  logic [V-1:0]   r_value;
  logic           r_ReqReady;
  logic           r_RespValid;
  logic [1:0]     r_RespOp;
  logic           r_RespHit;
  logic [V-1:0]   r_RespValue;
  logic           r_InitDone;
  logic [A-1:0]   r_RwAddr;
  logic           r_WrEnb;
  logic [A-1:0]   r_WrAddr;

  logic [KPW-1:0] w_keyPad;
  logic [A-1:0]   w_hash;
  logic           w_stValid;
  logic [K-1:0]   w_stKey;
  logic [V-1:0]   w_stValue;
  logic           w_match;
  logic [D-1:0]   w_newEntry;
  logic           w_wrEn;
  logic [D-1:0]   w_wrData;
  logic           w_hit;
  logic [V-1:0]   w_value;

  // Bucket address: XOR of A-bit key chunks, top chunk zero-padded.
  always_comb begin
    w_keyPad = KPW'(i_ReqKey);
    w_hash   = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      w_hash = w_hash ^ w_keyPad[i*A +: A];
    end
  end

  assign w_stValid  = i_RwDataOut[K+V];
  assign w_stKey    = i_RwDataOut[K+V-1:V];
  assign w_stValue  = i_RwDataOut[V-1:0];
  assign w_match    = w_stValid && (w_stKey == r_key);
  assign w_newEntry = D'({1'b1, r_key, r_value});

  always_comb begin
    w_wrEn   = 1'b0;
    w_wrData = '0;
    w_hit    = 1'b0;
    w_value  = '0;
    case (r_op)
      2'd0: begin
        w_hit   = w_match;
        w_value = w_match ? w_stValue : '0;
      end
      2'd1: begin
        if (!w_stValid || w_match) begin
          w_wrEn   = 1'b1;
          w_wrData = w_newEntry;
          w_hit    = 1'b1;
          w_value  = r_value;
        end else begin
          w_value  = w_stValue;
        end
      end
      2'd2: begin
        if (w_match) begin
          w_wrEn  = 1'b1;
          w_hit   = 1'b1;
          w_value = w_stValue;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state     <= INIT;
      r_op        <= '0;
      r_key       <= '0;
      r_value     <= '0;
      r_ReqReady  <= 1'b0;
      r_RespValid <= 1'b0;
      r_RespOp    <= '0;
      r_RespHit   <= 1'b0;
      r_RespValue <= '0;
      r_InitDone  <= 1'b0;
      r_RwAddr    <= '0;
      r_WrEnb     <= 1'b0;
      r_WrAddr    <= '0;
    end else begin
      case (r_state)
        // WrEnb low marks the first INIT cycle; WrAddr doubles as the clear counter.
        INIT: begin
          if (r_WrEnb && (r_WrAddr == '1)) begin
            r_WrEnb    <= 1'b0;
            r_WrAddr   <= '0;
            r_InitDone <= 1'b1;
            r_ReqReady <= 1'b1;
            r_state    <= IDLE;
          end else if (!r_WrEnb) begin
            r_WrEnb  <= 1'b1;
            r_WrAddr <= '0;
          end else begin
            r_WrAddr <= r_WrAddr + 1'b1;
          end
        end
        IDLE: begin
          if (i_ReqValid) begin
            r_op       <= i_ReqOp;
            r_key      <= i_ReqKey;
            r_value    <= i_ReqValue;
            r_RwAddr   <= w_hash;
            r_ReqReady <= 1'b0;
            r_state    <= READ;
          end
        end
        READ: r_state <= EVAL;
        EVAL: begin
          r_RespValid <= 1'b1;
          r_RespOp    <= r_op;
          r_RespHit   <= w_hit;
          r_RespValue <= w_value;
          r_state     <= RESP;
        end
        RESP: begin
          if (i_RespReady) begin
            r_RespValid <= 1'b0;
            r_ReqReady  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  // The EVAL write depends on same-cycle read data, so it is decoded, and reset kills it.
  assign o_RwEnb     = (r_state == EVAL) && !i_Rst && w_wrEn;
  assign o_RwData    = o_RwEnb ? w_wrData : '0;
  assign o_RwAddr    = r_RwAddr;
  assign o_ReqReady  = r_ReqReady;
  assign o_RespValid = r_RespValid;
  assign o_RespOp    = r_RespOp;
  assign o_RespHit   = r_RespHit;
  assign o_RespValue = r_RespValue;
  assign o_InitDone  = r_InitDone;
  assign o_WrEnb     = r_WrEnb;
  assign o_WrAddr    = r_WrAddr;
  assign o_WrData    = '0;

endmodule

// File: tb/tb_cam_bucket_ctrl.sv
// Scoreboard bench for cam_bucket_ctrl with a behavioural dual-port table RAM
// and directed lookup/insert/delete/collision/backpressure/reset vectors.
module tb_cam_bucket_ctrl;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqOp;
  logic [47:0] reqKey;
  logic [13:0] reqValue;
  logic        respValid;
  logic        respReady;
  logic [1:0]  respOp;
  logic        respHit;
  logic [13:0] respValue;
  logic        initDone;
  logic        rwEnb;
  logic [8:0]  rwAddr;
  logic [63:0] rwData;
  logic [63:0] rwDataOut;
  logic        wrEnb;
  logic [8:0]  wrAddr;
  logic [63:0] wrData;

  typedef struct {
    logic [1:0]  op;
    logic        hit;
    logic [13:0] val;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  logic [63:0] mem [0:511];

  cam_bucket_ctrl dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_ReqValid(reqValid), .o_ReqReady(reqReady), .i_ReqOp(reqOp),
    .i_ReqKey(reqKey), .i_ReqValue(reqValue),
    .o_RespValid(respValid), .i_RespReady(respReady), .o_RespOp(respOp),
    .o_RespHit(respHit), .o_RespValue(respValue), .o_InitDone(initDone),
    .o_RwEnb(rwEnb), .o_RwAddr(rwAddr), .o_RwData(rwData), .i_RwDataOut(rwDataOut),
    .o_WrEnb(wrEnb), .o_WrAddr(wrAddr), .o_WrData(wrData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table RAM: registered read, old data on read-during-write.
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = {2'b01, 48'(i), 14'h3FFF};
    rwDataOut = '0;
  end
  always @(posedge clk) begin
    if (wrEnb) mem[wrAddr] <= wrData;
    if (rwEnb) mem[rwAddr] <= rwData;
    rwDataOut <= mem[rwAddr];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (respValid && respReady) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_response", {respOp, respHit, respValue}, 64'hDEAD);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("resp_op", respOp, e.op);
        checkOutput("resp_hit", respHit, e.hit);
        checkOutput("resp_value", respValue, e.val);
      end
    end
  end

  task automatic initCheck();
    int cnt;
    int guard;
    logic addrOk, dataOk, earlyDone;
    cnt = 0; guard = 0; addrOk = 1'b1; dataOk = 1'b1; earlyDone = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("init_first_wrenb", {wrEnb, wrAddr}, {1'b1, 9'd0});
    while (wrEnb && guard < 700) begin
      if (wrAddr != 9'(cnt)) addrOk = 1'b0;
      if (wrData != 64'd0) dataOk = 1'b0;
      if (initDone || reqReady) earlyDone = 1'b1;
      cnt++;
      guard++;
      @(negedge clk);
    end
    checkOutput("init_wr_cycles", cnt, 512);
    checkOutput("init_addr_seq", addrOk, 1'b1);
    checkOutput("init_data_zero", dataOk, 1'b1);
    checkOutput("init_done_early", earlyDone, 1'b0);
    checkOutput("init_done_ready", {initDone, reqReady}, 2'b11);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [47:0] key, input logic [13:0] val,
                               input logic expHit, input logic [13:0] expVal, input logic expWr,
                               input logic [8:0] expAddr, input logic [63:0] expData, input int hold);
    int guard;
    int lat;
    logic [16:0] held;
    logic stable;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!reqReady && guard < 2000) begin
      guard++;
      @(negedge clk);
    end
    if (!reqReady) begin
      checkOutput("req_ready_timeout", reqReady, 1'b1);
      return;
    end
    respReady = (hold == 0);
    reqValid = 1'b1; reqOp = op; reqKey = key; reqValue = val;
    e.op = op; e.hit = expHit; e.val = expVal;
    expQ.push_back(e);
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 2) begin
        checkOutput("eval_rwaddr", rwAddr, expAddr);
        checkOutput("eval_rwenb", rwEnb, expWr);
        if (expWr) checkOutput("eval_rwdata", rwData, expData);
      end
      if (respValid) begin
        lat = n;
        break;
      end
    end
    checkOutput("resp_latency", lat, 3);
    if (lat == 0) return;
    if (hold == 0) begin
      @(negedge clk);
      checkOutput("ready_after_resp", {respValid, reqReady}, 2'b01);
    end else begin
      held = {respOp, respHit, respValue};
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!respValid || reqReady || ({respOp, respHit, respValue} != held)) stable = 1'b0;
      end
      checkOutput("backpressure_stable", stable, 1'b1);
      @(posedge clk);
      #1 respReady = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("ready_after_bp", {respValid, reqReady}, 2'b01);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; reqValid = 1'b0; reqOp = '0; reqKey = '0; reqValue = '0; respReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ctrl", {reqReady, respValid, respOp, respHit, respValue, initDone, rwEnb, wrEnb}, '0);
    checkOutput("reset_addr", {rwAddr, wrAddr}, '0);
    checkOutput("reset_data", rwData | wrData, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    initCheck();

    applyStimulus(2'd0, 48'h1, 14'h0, 1'b0, 14'h0, 1'b0, 9'd1, 64'd0, 0);
    applyStimulus(2'd1, 48'h1, 14'h155, 1'b1, 14'h155, 1'b1, 9'd1, {2'b01, 48'h1, 14'h155}, 0);
    applyStimulus(2'd0, 48'h1, 14'h0, 1'b1, 14'h155, 1'b0, 9'd1, 64'd0, 0);
    applyStimulus(2'd1, 48'h200, 14'h7, 1'b0, 14'h155, 1'b0, 9'd1, 64'd0, 0);
    applyStimulus(2'd1, 48'h1, 14'h22, 1'b1, 14'h22, 1'b1, 9'd1, {2'b01, 48'h1, 14'h22}, 0);
    applyStimulus(2'd0, 48'h1, 14'h0, 1'b1, 14'h22, 1'b0, 9'd1, 64'd0, 0);
    applyStimulus(2'd2, 48'h200, 14'h0, 1'b0, 14'h0, 1'b0, 9'd1, 64'd0, 0);
    applyStimulus(2'd2, 48'h1, 14'h0, 1'b1, 14'h22, 1'b1, 9'd1, 64'd0, 0);
    checkOutput("mem1_zeroed", mem[1], 64'd0);
    applyStimulus(2'd0, 48'h1, 14'h0, 1'b0, 14'h0, 1'b0, 9'd1, 64'd0, 0);

    // Multi-chunk hash: key 0xABCD12345678 folds to bucket 0x1C5.
    applyStimulus(2'd1, 48'hABCD12345678, 14'h3ABC, 1'b1, 14'h3ABC, 1'b1, 9'h1C5,
                  {2'b01, 48'hABCD12345678, 14'h3ABC}, 0);
    applyStimulus(2'd0, 48'hABCD12345678, 14'h0, 1'b1, 14'h3ABC, 1'b0, 9'h1C5, 64'd0, 10);
    applyStimulus(2'd3, 48'hABCD12345678, 14'h11, 1'b0, 14'h0, 1'b0, 9'h1C5, 64'd0, 0);

    // Reset while an insert is in EVAL.
    @(negedge clk);
    while (!reqReady) @(negedge clk);
    reqValid = 1'b1; reqOp = 2'd1; reqKey = 48'h5; reqValue = 14'h33;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_eval_rwenb", rwEnb, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_eval_mem5", mem[5], 64'd0);
    checkOutput("rst_no_resp", {respValid, initDone}, 2'b00);
    initCheck();
    applyStimulus(2'd0, 48'h5, 14'h0, 1'b0, 14'h0, 1'b0, 9'd5, 64'd0, 0);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_bucket_ctrl.md
# cam_bucket_ctrl

Lookup/insert/delete controller for the ToeCam session table. Accepts key-based requests on a valid/ready channel, hashes each key to a direct-mapped bucket, and drives the dual-port table RAM (one read/write port, one write-only port) directly upstream of it. Returns hit/status and the stored value on a valid/ready response channel. After reset it clears the whole table before accepting requests.

## Interface
- A, 9, RAM address bits; table holds 2^A buckets
- K, 48, key width
- V, 14, value width
- D, 64, RAM data width; D >= K+V+1
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- ReqValid  in  1  request present
- ReqReady  out  1  block can accept a request
- ReqOp  in  2  0 lookup, 1 insert, 2 delete, 3 reserved
- ReqKey  in  K  key
- ReqValue  in  V  value for insert; ignored otherwise
- RespValid  out  1  response present
- RespReady  in  1  consumer takes response
- RespOp  out  2  echo of ReqOp
- RespHit  out  1  lookup hit / insert ok / delete ok
- RespValue  out  V  see Operation
- InitDone  out  1  table clear complete
- RwEnb, RwAddr[A], RwData[D]  out  RAM read/write port controls
- RwDataOut  in  D  RAM read data, registered, 1-cycle latency, old data on read-during-write
- WrEnb, WrAddr[A], WrData[D]  out  RAM write-only port controls

## Operation
- Entry layout: bit K+V valid, [K+V-1:V] key, [V-1:0] value, bits above K+V written 0.
- Hash: split key into A-bit chunks from LSB, top chunk zero-padded; bucket address = XOR of all chunks.
- States: INIT, IDLE, READ, EVAL, RESP.
- INIT: address counter 0..2^A-1, WrEnb=1, WrData=0, one address per cycle; after writing 2^A-1 go IDLE, InitDone=1 (stays 1 until next Rst).
- IDLE: ReqReady=1. On ReqValid&ReqReady, register op, key, value, hashed address; go READ.
- READ: RwAddr=bucket, RwEnb=0; go EVAL.
- EVAL: match = valid bit set and stored key == ReqKey.
  - lookup: RespHit=match; RespValue=stored value if match else 0; no write.
  - insert: if !valid or match: RwEnb=1, RwData={1,key,value} at same RwAddr, RespHit=1, RespValue=new value (matching key overwrites value). Else collision: no write, RespHit=0, RespValue=stored value of the occupant.
  - delete: if match: RwEnb=1, RwData=0, RespHit=1, RespValue=removed value. Else no write, RespHit=0, RespValue=0.
  - op 3: no write, RespHit=0, RespValue=0.
  - Register response fields; go RESP.
- RESP: RespValid=1, fields stable until RespValid&RespReady; then IDLE.
- One request in flight; no read/write hazards possible.
- WrEnb used only in INIT; RwEnb only in EVAL.

## Timing
- Reset values: ReqReady 0, RespValid 0, RespOp 0, RespHit 0, RespValue 0, InitDone 0, RwEnb 0, RwAddr 0, RwData 0, WrEnb 0, WrAddr 0, WrData 0. First cycle after Rst deasserted: INIT begins (WrEnb=1, WrAddr=0).
- InitDone and ReqReady rise the cycle after WrAddr=2^A-1 is written (2^A cycles of INIT).
- Accept at cycle T; RwAddr presented T+1; RwDataOut valid and write (if any) at T+2; RespValid=1 at T+3.
- Response consumed at cycle R; ReqReady=1 at R+1. Best-case throughput: one op per 4 cycles.
- RespValid with RespReady low: hold indefinitely, ReqReady stays 0.
- Rst mid-operation: in-flight request dropped without response, pending EVAL write suppressed, INIT restarts from address 0.

## Test plan
- Reset, then count cycles: WrEnb high exactly 512 cycles with WrAddr 0..511, WrData 0; InitDone/ReqReady rise the next cycle; lookup key 0x1 -> RespHit 0, RespValue 0.
- Insert key 0x1 value 0x155 -> write at address 1 with data valid=1 at bit 62; RespHit 1; lookup key 0x1 -> RespHit 1, RespValue 0x155; RespValid at exactly T+3.
- Collision: after insert key 0x1, insert key 0x200 (also address 1) value 0x7 -> RespHit 0, RespValue 0x155, no RwEnb; re-insert key 0x1 value 0x22 -> RespHit 1, lookup returns 0x22.
- Delete key 0x200 when absent -> RespHit 0; delete key 0x1 -> RespHit 1, RespValue 0x22, entry zeroed; subsequent lookup key 0x1 -> RespHit 0.
- Backpressure: hold RespReady low 10 cycles -> RespValid and fields stable, ReqReady 0 throughout; ReqReady 1 the cycle after handshake. Op 3 -> RespHit 0, no write.
- Assert Rst during EVAL of an insert -> no RwEnb write, no response, INIT restarts at WrAddr 0; lookup of that key after init -> RespHit 0.
